// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequencer for an unsigned right-shift multiplier that
// owns the M/A/Q registers and drives an external WIDTH+1-bit-result adder.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic [WIDTH:0]     add_s,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                m_d     = multiplicand;
                q_d     = multiplier;
                a_d     = '0;
                cnt_d   = '0;
                state_d = S_RUN;
            end
        end else if (state_q == S_RUN) begin
            // The adder carry lands in A's MSB as the pair shifts right.
            {a_d, q_d} = {add_s, q_q[WIDTH-1:1]};
            cnt_d      = cnt_q + CNT_W'(1);
            state_d    = (cnt_q == CNT_W'(WIDTH - 1)) ? S_DONE : S_RUN;
        end else begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end
    assign add_a   = a_q;
    assign add_b   = q_q[0] ? m_q : '0;
    assign busy    = (state_q == S_RUN) || (state_q == S_DONE);
    assign done    = (state_q == S_DONE);
    assign product = {a_q, q_q};
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: directed and random checks of the shift-add multiplier
// sequencer against a cycle-timing and arithmetic model of its contract.
module tb_shift_add_mult_ctrl;
    localparam int W = 32;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic [W-1:0]  add_a, add_b;
    logic [W:0]    add_s;
    logic          busy, done;
    logic [2*W-1:0] product;
    int n_cmp = 0;
    int n_bad = 0;

    shift_add_mult_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .busy(busy), .done(done), .product(product)
    );

    // External ripple adder stand-in.
    assign add_s = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: m_left counts cycles still busy; done is the last busy cycle.
    int            m_left = 0;
    logic [63:0]   m_pend = '0;
    logic [63:0]   m_last = '0;
    logic [W-1:0]  m_m = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_last <= '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= W + 1;
                m_pend <= 64'(multiplicand) * 64'(multiplier);
                m_m    <= multiplicand;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_last <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 64'(busy), 64'(m_left != 0));
            check("done", 64'(done), 64'(m_left == 1));
            if (m_left <= 1) check("product", product, m_last);
            else begin
                check("add_a", 64'(add_a), 64'(product[2*W-1:W]));
                check("add_b", 64'(add_b), product[0] ? 64'(m_m) : 64'd0);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] exp,
                          input bit chk_lat);
        int k, nb;
        @(negedge clk);
        start = 1'b1; multiplicand = a; multiplier = b;
        @(negedge clk);
        start = 1'b0;
        k = 0; nb = 0;
        while (!done && k < 100) begin
            if (busy) nb++;
            @(negedge clk);
            k++;
        end
        if (busy) nb++;
        check("op_done", 64'(done), 64'd1);
        check("op_product", product, exp);
        if (chk_lat) begin
            check("op_latency", 64'(k), 64'd32);
            check("op_busy_cycles", 64'(nb), 64'd33);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(32'd5, 32'd7, 64'h0000_0000_0000_0023, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        run_op(32'd0, 32'h1234_5678, 64'd0, 1'b0);
        run_op(32'h1234_5678, 32'd0, 64'd0, 1'b0);
        run_op(32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, 1'b0);
        repeat (3) @(negedge clk);
        check("idle_hold", product, 64'h0000_0000_8000_0000);
        // Start held high; operands change right after capture.
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd3; multiplier = 32'd4;
        @(negedge clk);
        multiplicand = 32'd9; multiplier = 32'd9;
        k = 0;
        while (!done && k < 100) begin @(negedge clk); k++; end
        check("held_first", product, 64'd12);
        k = 0;
        @(negedge clk);
        while (!done && k < 100) begin @(negedge clk); k++; end
        check("held_spacing", 64'(k + 1), 64'd34);
        check("held_second", product, 64'd81);
        start = 1'b0;
        repeat (3) @(negedge clk);
        // Abort mid-run with asynchronous reset.
        start = 1'b1; multiplicand = 32'h1234; multiplier = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        check("abort_add_a", 64'(add_a), 64'd0);
        check("abort_add_b", 64'(add_b), 64'd0);
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        run_op(32'd6, 32'd7, 64'd42, 1'b1);
        repeat (2) @(negedge clk);
        // Random back-to-back operations with start held high.
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            k = 0;
            do begin
                multiplicand = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
                multiplier   = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
                @(negedge clk);
                k++;
            end while (!done && k < 60);
            if (i > 0) check("rand_spacing", 64'(k), 64'd34);
            else check("rand_first_done", 64'(done), 64'd1);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("final_idle", 64'(busy), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
